operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Upstream of the FPU datapath FSM. Captures the two 32-bit IEEE-754 operands, n0 and n1, one byte at a time from the switch bank.
- Synchronises and debounces the raw save and start push-buttons.
- Tracks which byte lanes have been written.
- Presents both operands to the FSM through a valid/ready handshake. This replaces the combinational latch-based operand entry in the FPU top.

Parameters:
- DB_COUNT, 4, consecutive stable cycles required before a debounced button changes level. Board build sets 1_000_000, which is 10 ms at 100 MHz.
- CNT_W, 20, debounce counter width. Must satisfy 2^CNT_W > DB_COUNT.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- save_btn  input  1  raw, asynchronous save push-button
- start_btn  input  1  raw, asynchronous start push-button
- datawork  input  1  write enable switch; saves are ignored when 0
- selnum  input  1  target operand: 0 = n0, 1 = n1
- seldata  input  2  byte lane: 0 = [7:0] through 3 = [31:24]
- datain  input  8  byte to write
- op_ready  input  1  FSM accepts the operand pair
- n0  output  32  operand 0
- n1  output  32  operand 1
- op_valid  output  1  operand pair offered to the FSM
- byte_mask  output  8  bit {selnum,seldata} set once that lane is written
- start_err  output  1  sticky flag: start was pressed with an incomplete mask

Behaviour:
- Reset (reset=0, asynchronous):
  - n0, n1, byte_mask = 0; op_valid = 0; start_err = 0; state = IDLE.
  - Synchroniser flops, debounced levels and debounce counters = 0.
  - Reset mid-handshake drops op_valid immediately and discards the loaded operands.
- Button path, identical per button:
  - 2-flop synchroniser, then debouncer, then rising-edge detector.
  - Debouncer: a counter increments while the synchronised level differs from the debounced level and clears when they are equal. When the count reaches DB_COUNT, the debounced level takes the synchronised level and the counter clears.
  - A bounce shorter than DB_COUNT cycles produces no change.
  - Edge detector emits a 1-cycle pulse on a debounced 0->1 transition. Release produces no pulse.
- Fixed latency: a raw clean rising edge sampled at clock edge k gives a pulse during the cycle after edge k+DB_COUNT+2. The register update lands at edge k+DB_COUNT+3.
- FSM states IDLE, ARMED, PRESENT:
  - IDLE: byte_mask != 8'hFF.
  - ARMED: byte_mask == 8'hFF, op_valid = 0.
  - PRESENT: op_valid = 1.
- Save pulse, acting in IDLE or ARMED only:
  - Condition: datawork=1.
  - Action: writes datain to operand selnum, lane seldata. Other lanes are unchanged.
  - byte_mask bit (selnum*4+seldata) is set. Rewriting a lane overwrites the data and leaves the mask unchanged.
  - start_err clears.
  - Save with datawork=0: no effect.
  - Save in PRESENT: ignored, operands frozen.
- Transitions:
  - IDLE -> ARMED on the edge where the mask becomes 8'hFF.
  - Start pulse in ARMED -> PRESENT; op_valid=1 from the next cycle.
  - Start pulse in IDLE: state is unchanged, start_err=1.
  - Start pulse in PRESENT: ignored.
- Handshake:
  - op_valid holds, and n0/n1 stay stable, until sampled op_valid & op_ready at an edge.
  - At that edge: op_valid -> 0, byte_mask -> 0, state -> IDLE. n0/n1 keep their values for display.
  - op_ready while op_valid=0 has no effect.
- Simultaneous save and start pulses in the same cycle:
  - Save is applied first.
  - Start is evaluated against the pre-save mask. A start in IDLE therefore sets start_err even if the save completes the mask; the save clears start_err only when start is absent.
- No wrap-around: all lane indices 0..3 are valid, and the debounce counter never exceeds DB_COUNT.

Test Plan:
- Reset, then hold reset=1, DB_COUNT=4. Raw save_btn 0->1 with datawork=1, selnum=0, seldata=2, datain=8'hA5. Required: n0 == 32'h00A5_0000 exactly 7 edges after the press is sampled, and byte_mask == 8'h04.
- Save_btn glitch high for 3 cycles then low -> no write; n0, n1 and byte_mask unchanged.
- Load n0=32'h3FC0_0000 and n1=32'h4020_0000 through 8 saves -> byte_mask=8'hFF, state ARMED, op_valid=0. Start -> op_valid=1. Hold op_ready=0 for 5 cycles: op_valid stays 1 and an extra save is ignored. Raise op_ready -> op_valid=0 next cycle, byte_mask=0, n0/n1 retained.
- Start with byte_mask=8'h7F -> start_err=1, op_valid stays 0. Next save -> start_err=0.
- Save with datawork=0 -> no change. Rewrite lane 0 of n1 with 8'h11, then 8'h22 -> n1[7:0]=8'h22, byte_mask bit 4 set once.
- Assert reset=0 while op_valid=1 -> op_valid, n0, n1, byte_mask and start_err all 0 without waiting for a clock edge.

Source files
------------

// File: rtl/operand_loader.sv
// Byte-wise operand entry for the FPU: conditioned save/start buttons, lane
// tracking, and a valid/ready hand-off of the n0/n1 pair to the datapath FSM.

module op_btn_cond #(
  parameter int DB_COUNT = 4,
  parameter int CNT_W    = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_COUNT);

  logic [1:0]       sync_q, sync_d;
  logic             db_q, db_d, db_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count only while the synchronised level disagrees; accept it after DB_COUNT.
  always_comb begin
    sync_d = {sync_q[0], raw};
    db_d   = db_q;
    cnt_d  = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == DB_MAX) db_d  = sync_q[1];
      else                 cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse = db_q & ~db_dly_q;
endmodule

module operand_loader #(
  parameter int DB_COUNT = 4,
  parameter int CNT_W    = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        save_btn,
  input  logic        start_btn,
  input  logic        datawork,
  input  logic        selnum,
  input  logic [1:0]  seldata,
  input  logic [7:0]  datain,
  input  logic        op_ready,
  output logic [31:0] n0,
  output logic [31:0] n1,
  output logic        op_valid,
  output logic [7:0]  byte_mask,
  output logic        start_err
);
  typedef enum logic [1:0] {IDLE, ARMED, PRESENT} state_t;

  state_t      state_q, state_d;
  logic [31:0] n0_q, n0_d, n1_q, n1_d;
  logic [7:0]  mask_q, mask_d;
  logic        err_q, err_d;
  logic [1:0]  btn_raw, btn_pulse;
  logic        save_p, start_p, save_en;

  assign btn_raw = {start_btn, save_btn};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    op_btn_cond #(.DB_COUNT(DB_COUNT), .CNT_W(CNT_W)) u_cond (
      .clock (clock),
      .reset (reset),
      .raw   (btn_raw[g]),
      .pulse (btn_pulse[g])
    );
  end

  assign save_p  = btn_pulse[0];
  assign start_p = btn_pulse[1];
  assign save_en = save_p & datawork & (state_q != PRESENT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Start is judged on the current state, i.e. the pre-save mask.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mask_d == 8'hFF) state_d = ARMED;
      ARMED:   if (start_p)         state_d = PRESENT;
      PRESENT: if (op_ready)        state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    n0_d   = n0_q;
    n1_d   = n1_q;
    mask_d = mask_q;
    err_d  = err_q;
    if (save_en) begin
      if (selnum) n1_d[{seldata, 3'b000} +: 8] = datain;
      else        n0_d[{seldata, 3'b000} +: 8] = datain;
      mask_d[{selnum, seldata}] = 1'b1;
      if (!start_p) err_d = 1'b0;
    end
    if (start_p && state_q == IDLE) err_d = 1'b1;
    if (state_q == PRESENT && op_ready) mask_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n0_q   <= '0;
      n1_q   <= '0;
      mask_q <= '0;
      err_q  <= 1'b0;
    end else begin
      n0_q   <= n0_d;
      n1_q   <= n1_d;
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end

  assign n0        = n0_q;
  assign n1        = n1_q;
  assign byte_mask = mask_q;
  assign start_err = err_q;
  assign op_valid  = (state_q == PRESENT);
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: latency, debounce, load/handshake,
// start error, write-enable, lane rewrite and async reset.

module tb_operand_loader;
  logic        clock = 1'b0;
  logic        reset;
  logic        save_btn, start_btn, datawork, selnum, op_ready;
  logic [1:0]  seldata;
  logic [7:0]  datain;
  logic [31:0] n0, n1;
  logic        op_valid, start_err;
  logic [7:0]  byte_mask;
  int          n_cmp = 0;
  int          n_err = 0;

  operand_loader #(.DB_COUNT(4), .CNT_W(20)) dut (
    .clock     (clock),
    .reset     (reset),
    .save_btn  (save_btn),
    .start_btn (start_btn),
    .datawork  (datawork),
    .selnum    (selnum),
    .seldata   (seldata),
    .datain    (datain),
    .op_ready  (op_ready),
    .n0        (n0),
    .n1        (n1),
    .op_valid  (op_valid),
    .byte_mask (byte_mask),
    .start_err (start_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_save(input logic we, input logic sel, input logic [1:0] lane,
                         input logic [7:0] data);
    datawork = we; selnum = sel; seldata = lane; datain = data;
    save_btn = 1'b1; cyc(10);
    save_btn = 1'b0; cyc(10);
  endtask

  task automatic do_start();
    start_btn = 1'b1; cyc(10);
    start_btn = 1'b0; cyc(10);
  endtask

  task automatic load_all(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) do_save(1'b1, 1'b0, 2'(i), a[i*8 +: 8]);
    for (int i = 0; i < 4; i++) do_save(1'b1, 1'b1, 2'(i), b[i*8 +: 8]);
  endtask

  initial begin
    reset = 1'b0; save_btn = 0; start_btn = 0; datawork = 0; selnum = 0;
    seldata = 0; datain = 0; op_ready = 0;
    cyc(3);
    chk("rst_n0", n0, 32'h0);
    chk("rst_n1", n1, 32'h0);
    chk("rst_mask", {24'h0, byte_mask}, 32'h0);
    chk("rst_valid", {31'h0, op_valid}, 32'h0);
    chk("rst_err", {31'h0, start_err}, 32'h0);
    reset = 1'b1;
    cyc(3);

    // Press sampled at edge k: write must land at edge k+7, not k+6.
    datawork = 1; selnum = 0; seldata = 2; datain = 8'hA5;
    save_btn = 1'b1;
    cyc(7);
    chk("lat_early_n0", n0, 32'h0);
    cyc(1);
    chk("lat_n0", n0, 32'h00A5_0000);
    chk("lat_mask", {24'h0, byte_mask}, 32'h04);
    cyc(2);
    save_btn = 1'b0; cyc(10);

    // 3-cycle glitch is shorter than the debounce window.
    seldata = 0; datain = 8'hFF;
    save_btn = 1'b1; cyc(3); save_btn = 1'b0; cyc(12);
    chk("glitch_n0", n0, 32'h00A5_0000);
    chk("glitch_n1", n1, 32'h0);
    chk("glitch_mask", {24'h0, byte_mask}, 32'h04);

    // Seven lanes, then start with an incomplete mask.
    for (int i = 0; i < 4; i++) do_save(1'b1, 1'b0, 2'(i), 8'(32'h3FC0_0000 >> (i*8)));
    for (int i = 0; i < 3; i++) do_save(1'b1, 1'b1, 2'(i), 8'(32'h4020_0000 >> (i*8)));
    chk("part_mask", {24'h0, byte_mask}, 32'h7F);
    do_start();
    chk("err_set", {31'h0, start_err}, 32'h1);
    chk("err_valid", {31'h0, op_valid}, 32'h0);
    do_save(1'b1, 1'b1, 2'd3, 8'h40);
    chk("err_clr", {31'h0, start_err}, 32'h0);
    chk("full_mask", {24'h0, byte_mask}, 32'hFF);
    chk("armed_valid", {31'h0, op_valid}, 32'h0);
    chk("load_n0", n0, 32'h3FC0_0000);
    chk("load_n1", n1, 32'h4020_0000);

    do_start();
    chk("pres_valid", {31'h0, op_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("hold_valid", {31'h0, op_valid}, 32'h1);
    end
    do_save(1'b1, 1'b0, 2'd0, 8'hEE);
    chk("frozen_n0", n0, 32'h3FC0_0000);
    chk("frozen_valid", {31'h0, op_valid}, 32'h1);
    op_ready = 1'b1;
    cyc(1);
    op_ready = 1'b0;
    chk("hs_valid", {31'h0, op_valid}, 32'h0);
    chk("hs_mask", {24'h0, byte_mask}, 32'h0);
    chk("hs_n0", n0, 32'h3FC0_0000);
    chk("hs_n1", n1, 32'h4020_0000);

    do_save(1'b0, 1'b1, 2'd0, 8'h99);
    chk("we0_n1", n1, 32'h4020_0000);
    chk("we0_mask", {24'h0, byte_mask}, 32'h0);
    do_save(1'b1, 1'b1, 2'd0, 8'h11);
    do_save(1'b1, 1'b1, 2'd0, 8'h22);
    chk("rw_n1", n1, 32'h4020_0022);
    chk("rw_mask", {24'h0, byte_mask}, 32'h10);

    load_all(32'h1234_5678, 32'h9ABC_DEF0);
    do_start();
    chk("pre_rst_valid", {31'h0, op_valid}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {31'h0, op_valid}, 32'h0);
    chk("arst_n0", n0, 32'h0);
    chk("arst_n1", n1, 32'h0);
    chk("arst_mask", {24'h0, byte_mask}, 32'h0);
    chk("arst_err", {31'h0, start_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
